// File: rtl/ram_dp_responder.sv
// Dual-port RAM responder: port 1 read-only (fetch), port 2 read/write (data/DMA), one shared array.
// Latency: ack in cycle 1+WAITn after stb first seen high; read data registered on the edge entering ACK.
// Backpressure: none inside; each port accepts a new stb only in IDLE. Optional macro RAM_DP_RESPONDER_BYPASS_EN.
module ram_dp_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT1  = 0,
    parameter int WAIT2  = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ram_stb_i,
    output logic        ram_ack_o,
    input  logic [15:0] ram_addr_i,
    output logic [31:0] ram_data_o,
    input  logic        ram2_stb_i,
    output logic        ram2_ack_o,
    input  logic        ram2_we_i,
    input  logic [15:0] ram2_addr_i,
    input  logic [31:0] ram2_data_i,
    output logic [31:0] ram2_data_o
);

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] W1    = 4'(WAIT1);
    localparam logic [3:0] W2    = 4'(WAIT2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    logic [31:0] mem [DEPTH];

    // Port 1 state
    state_t              p1_st, p1_nxt;
    logic [3:0]          p1_cnt, p1_cnt_nxt;
    logic [ADDR_W-1:0]   p1_addr_q;
    logic [ADDR_W-1:0]   p1_addr;
    logic                p1_go;
    logic [31:0]         p1_rd_word;

    // Port 2 state
    state_t              p2_st, p2_nxt;
    logic [3:0]          p2_cnt, p2_cnt_nxt;
    logic [ADDR_W-1:0]   p2_addr_q;
    logic                p2_we_q;
    logic [31:0]         p2_wdata_q;
    logic [ADDR_W-1:0]   p2_addr;
    logic                p2_we;
    logic [31:0]         p2_wdata;
    logic                p2_go;
    logic                p2_wr;

    // Upper address bits are deliberately dropped, so addresses wrap modulo depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_addr_i[15:ADDR_W], ram2_addr_i[15:ADDR_W]};

    // In IDLE the request is taken straight from the inputs (WAITn=0 enters ACK
    // on the same edge that latches); afterwards the latched copy is used.
    assign p1_addr  = (p1_st == ST_IDLE) ? ram_addr_i[ADDR_W-1:0]  : p1_addr_q;
    assign p2_addr  = (p2_st == ST_IDLE) ? ram2_addr_i[ADDR_W-1:0] : p2_addr_q;
    assign p2_we    = (p2_st == ST_IDLE) ? ram2_we_i               : p2_we_q;
    assign p2_wdata = (p2_st == ST_IDLE) ? ram2_data_i             : p2_wdata_q;

    // A write only happens on a real clock edge out of reset.
    assign p2_wr = p2_go & p2_we & sys_rst;

    assign ram_ack_o  = (p1_st == ST_ACK);
    assign ram2_ack_o = (p2_st == ST_ACK);

    // Port 1 next-state and wait counter
    always_comb begin
        p1_nxt     = p1_st;
        p1_cnt_nxt = p1_cnt;
        p1_go      = 1'b0;
        case (p1_st)
            ST_IDLE: begin
                if (ram_stb_i) begin
                    if (W1 == 4'd0) begin
                        p1_nxt = ST_ACK;
                        p1_go  = 1'b1;
                    end else begin
                        p1_nxt     = ST_WAIT;
                        p1_cnt_nxt = W1 - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (p1_cnt == 4'd0) begin
                    p1_nxt = ST_ACK;
                    p1_go  = 1'b1;
                end else begin
                    p1_cnt_nxt = p1_cnt - 4'd1;
                end
            end
            ST_ACK:  p1_nxt = ST_IDLE;
            default: p1_nxt = ST_IDLE;
        endcase
    end

    // Port 2 next-state and wait counter
    always_comb begin
        p2_nxt     = p2_st;
        p2_cnt_nxt = p2_cnt;
        p2_go      = 1'b0;
        case (p2_st)
            ST_IDLE: begin
                if (ram2_stb_i) begin
                    if (W2 == 4'd0) begin
                        p2_nxt = ST_ACK;
                        p2_go  = 1'b1;
                    end else begin
                        p2_nxt     = ST_WAIT;
                        p2_cnt_nxt = W2 - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (p2_cnt == 4'd0) begin
                    p2_nxt = ST_ACK;
                    p2_go  = 1'b1;
                end else begin
                    p2_cnt_nxt = p2_cnt - 4'd1;
                end
            end
            ST_ACK:  p2_nxt = ST_IDLE;
            default: p2_nxt = ST_IDLE;
        endcase
    end

    // Port 1 read word, optionally forwarding a same-edge port 2 write
    always_comb begin
        p1_rd_word = mem[p1_addr];
`ifdef RAM_DP_RESPONDER_BYPASS_EN
        if (p2_wr && (p2_addr == p1_addr)) begin
            p1_rd_word = p2_wdata;
        end
`endif
    end

    // Port 1 state, request latch and read data register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            p1_st      <= ST_IDLE;
            p1_cnt     <= 4'd0;
            p1_addr_q  <= '0;
            ram_data_o <= 32'd0;
        end else begin
            p1_st  <= p1_nxt;
            p1_cnt <= p1_cnt_nxt;
            if (p1_st == ST_IDLE && ram_stb_i) begin
                p1_addr_q <= ram_addr_i[ADDR_W-1:0];
            end
            if (p1_go) begin
                ram_data_o <= p1_rd_word;
            end
        end
    end

    // Port 2 state, request latch and read data register (writes leave data_o alone)
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            p2_st       <= ST_IDLE;
            p2_cnt      <= 4'd0;
            p2_addr_q   <= '0;
            p2_we_q     <= 1'b0;
            p2_wdata_q  <= 32'd0;
            ram2_data_o <= 32'd0;
        end else begin
            p2_st  <= p2_nxt;
            p2_cnt <= p2_cnt_nxt;
            if (p2_st == ST_IDLE && ram2_stb_i) begin
                p2_addr_q  <= ram2_addr_i[ADDR_W-1:0];
                p2_we_q    <= ram2_we_i;
                p2_wdata_q <= ram2_data_i;
            end
            if (p2_go && !p2_we) begin
                ram2_data_o <= mem[p2_addr];
            end
        end
    end

    // Shared array write from port 2; contents survive reset
    always_ff @(posedge sys_clk) begin
        if (p2_wr) begin
            mem[p2_addr] <= p2_wdata;
        end
    end

endmodule
